// File: rtl/seg14_scroller.sv
// 14-segment multiplexed display driver with a writable message RAM and optional scrolling.
// Define SEG14_BLANKING_EN to insert a one-cycle blank slot after every digit dwell.
//   state    | meaning
//   PH_SHOW  | digit r_k is driven for DWELL cycles
//   PH_BLANK | all selects off for one cycle before the next digit
module seg14_scroller #(
  parameter int DIGITS        = 12,
  parameter int MSG_DEPTH     = 32,
  parameter int DWELL         = 1,
  parameter int SCROLL_FRAMES = 4,
  localparam int AW = $clog2(MSG_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [7:0]        i_wr_data,
  input  logic [AW:0]       i_msg_len,
  input  logic              i_scroll_en,
  output logic [DIGITS-1:0] o_sel,
  output logic [13:0]       o_segm,
  output logic              o_frame_done
);

  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  logic [7:0]        r_mem [MSG_DEPTH];
  logic [KW-1:0]     r_k;
  logic [DW-1:0]     r_dwell;
  logic [FW-1:0]     r_fcnt;
  logic [AW-1:0]     r_off;
  logic [AW:0]       r_len;
  logic [DIGITS-1:0] r_sel;
  logic [13:0]       r_segm;
  logic              r_frame_done;

`ifdef SEG14_BLANKING_EN
  typedef enum logic {PH_SHOW, PH_BLANK} phase_t;
  phase_t r_phase;
`endif

  logic          w_dwell_end;
  logic          w_blank;
  logic          w_adv;
  logic          w_last;
  logic          w_frame_end;
  logic          w_fcnt_end;
  logic [AW:0]   w_len_new;
  logic [AW:0]   w_k_ext;
  logic [AW:0]   w_sum;
  logic [AW:0]   w_mod;
  logic [AW:0]   w_off_inc;
  logic [AW:0]   w_off_step;
  logic [AW-1:0] w_rd_idx;
  logic          w_show;
  logic [7:0]    w_char;
  logic [13:0]   w_font;

  // Lowercase folds to uppercase; anything outside A-Z, 0-9 and space is blank.
  function automatic logic [13:0] f_font(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? (c - 8'h20) : c;
    case (u)
      "0":     f_font = 14'h3F00;
      "1":     f_font = 14'h1800;
      "2":     f_font = 14'h36C0;
      "3":     f_font = 14'h3CC0;
      "4":     f_font = 14'h19C0;
      "5":     f_font = 14'h2DC0;
      "6":     f_font = 14'h2FC0;
      "7":     f_font = 14'h3800;
      "8":     f_font = 14'h3FC0;
      "9":     f_font = 14'h3DC0;
      "A":     f_font = 14'h3BC0;
      "B":     f_font = 14'h3C52;
      "C":     f_font = 14'h2700;
      "D":     f_font = 14'h3C12;
      "E":     f_font = 14'h2780;
      "F":     f_font = 14'h2380;
      "G":     f_font = 14'h2F40;
      "H":     f_font = 14'h1BC0;
      "I":     f_font = 14'h2412;
      "J":     f_font = 14'h1E00;
      "K":     f_font = 14'h0389;
      "L":     f_font = 14'h0700;
      "M":     f_font = 14'h1B28;
      "N":     f_font = 14'h1B21;
      "O":     f_font = 14'h3F00;
      "P":     f_font = 14'h33C0;
      "Q":     f_font = 14'h3F01;
      "R":     f_font = 14'h33C1;
      "S":     f_font = 14'h2DC0;
      "T":     f_font = 14'h2012;
      "U":     f_font = 14'h1F00;
      "V":     f_font = 14'h030C;
      "W":     f_font = 14'h1B05;
      "X":     f_font = 14'h002D;
      "Y":     f_font = 14'h002A;
      "Z":     f_font = 14'h240C;
      default: f_font = 14'h0000;
    endcase
  endfunction

  assign w_dwell_end = (r_dwell == DW'(DWELL - 1));
`ifdef SEG14_BLANKING_EN
  assign w_blank = (r_phase == PH_BLANK);
  assign w_adv   = w_blank;
`else
  assign w_blank = 1'b0;
  assign w_adv   = w_dwell_end;
`endif
  assign w_last      = (r_k == KW'(DIGITS - 1));
  assign w_frame_end = w_adv && w_last;
  assign w_fcnt_end  = (r_fcnt == FW'(SCROLL_FRAMES - 1));

  assign w_len_new = (i_msg_len > (AW+1)'(MSG_DEPTH)) ? (AW+1)'(MSG_DEPTH) : i_msg_len;

  // Offset stays below len and k below DIGITS <= MSG_DEPTH, so the sum fits in AW+1 bits.
  assign w_k_ext  = (AW+1)'(r_k);
  assign w_sum    = {1'b0, r_off} + w_k_ext;
  assign w_mod    = (r_len == '0) ? '0 : (w_sum % r_len);
  assign w_rd_idx = i_scroll_en ? AW'(w_mod) : AW'(r_k);
  assign w_show   = (r_len != '0) && (i_scroll_en || (w_k_ext < r_len));
  assign w_char   = r_mem[w_rd_idx];
  assign w_font   = f_font(w_char);

  assign w_off_inc  = {1'b0, r_off} + (AW+1)'(1);
  assign w_off_step = !w_fcnt_end ? {1'b0, r_off} :
                      (w_off_inc >= r_len) ? '0 : w_off_inc;

  // Read-before-write falls out of the combinational read against this registered write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem <= '{default: 8'h20};
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_k          <= '0;
      r_dwell      <= '0;
      r_fcnt       <= '0;
      r_off        <= '0;
      r_len        <= '0;
      r_sel        <= '0;
      r_segm       <= '0;
      r_frame_done <= 1'b0;
`ifdef SEG14_BLANKING_EN
      r_phase      <= PH_SHOW;
`endif
    end else begin
`ifdef SEG14_BLANKING_EN
      if (r_phase == PH_SHOW) begin
        if (w_dwell_end) begin
          r_dwell <= '0;
          r_phase <= PH_BLANK;
        end else begin
          r_dwell <= r_dwell + DW'(1);
        end
      end else begin
        r_phase <= PH_SHOW;
        r_k     <= w_last ? '0 : r_k + KW'(1);
      end
`else
      if (w_dwell_end) begin
        r_dwell <= '0;
        r_k     <= w_last ? '0 : r_k + KW'(1);
      end else begin
        r_dwell <= r_dwell + DW'(1);
      end
`endif
      if (w_frame_end) begin
        r_len  <= w_len_new;
        r_off  <= (!i_scroll_en || (w_off_step >= w_len_new)) ? '0 : AW'(w_off_step);
        r_fcnt <= (!i_scroll_en || w_fcnt_end) ? '0 : r_fcnt + FW'(1);
      end else if (!i_scroll_en) begin
        r_off  <= '0;
        r_fcnt <= '0;
      end

      r_sel        <= w_blank ? '0 : (DIGITS'(1) << r_k);
      r_segm       <= (w_blank || !w_show) ? '0 : w_font;
      r_frame_done <= w_frame_end;
    end
  end

  assign o_sel        = r_sel;
  assign o_segm       = r_segm;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_seg14_scroller.sv
// Scoreboard bench for seg14_scroller: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_seg14_scroller;
  localparam int DIGITS    = 12;
  localparam int MSG_DEPTH = 32;
  localparam int AW        = 5;
`ifdef SEG14_BLANKING_EN
  localparam int DWELL = 2;
  localparam int BLANK = 1;
`else
  localparam int DWELL = 1;
  localparam int BLANK = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [7:0]        wr_data;
  logic [AW:0]       msg_len;
  logic              scroll_en;
  logic [DIGITS-1:0] sel;
  logic [13:0]       segm;
  logic              frame_done;

  always #5 clk = ~clk;

  seg14_scroller #(
    .DIGITS(DIGITS), .MSG_DEPTH(MSG_DEPTH), .DWELL(DWELL), .SCROLL_FRAMES(1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_msg_len(msg_len), .i_scroll_en(scroll_en),
    .o_sel(sel), .o_segm(segm), .o_frame_done(frame_done)
  );

  typedef struct {
    int          cyc;
    logic [11:0] sel;
    logic [13:0] segm;
    logic        fd;
  } exp_t;

  // kind 0 = buffer write, kind 1 = change msg_len input
  typedef struct {
    int         slot;
    int         kind;
    logic [7:0] a;
    logic [7:0] d;
  } act_t;

  exp_t       sbq[$];
  act_t       wq[$];
  logic [7:0] sh [MSG_DEPTH];
  int         n_cyc  = 0;
  int         n_chk  = 0;
  int         n_pass = 0;

  always @(posedge clk) n_cyc <= n_cyc + 1;

  function automatic logic [13:0] ref_font(input logic [7:0] c);
    case (c)
      8'h20, "?": return 14'h0000;
      "P":        return 14'h33C0;
      "U", "u":   return 14'h1F00;
      "S":        return 14'h2DC0;
      "Y", "y":   return 14'h002A;
      "T":        return 14'h2012;
      "A":        return 14'h3BC0;
      "Z":        return 14'h240C;
      default:    return 14'h3FFF;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", nm, n_cyc, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0 && sbq[0].cyc < n_cyc) begin
      n_chk++;
      $display("FAIL stale cyc=%0d got=unchecked want=%0d", n_cyc, sbq[0].cyc);
      void'(sbq.pop_front());
    end
    if (sbq.size() > 0 && sbq[0].cyc == n_cyc) begin
      e = sbq.pop_front();
      chk("sel", 32'(sel), 32'(e.sel));
      chk("segm", 32'(segm), 32'(e.segm));
      chk("frame_done", 32'(frame_done), 32'(e.fd));
    end
    if (n_cyc > 0) chk("onehot", 32'($countones(sel) <= 1), 32'd1);
  end

  // One frame (or its first nslots digits); len/off are the expected active length and offset.
  task automatic frame(input int len, input int off, input bit scr, input int nslots);
    scroll_en = scr;
    for (int k = 0; k < nslots; k++) begin
      for (int d = 0; d < DWELL; d++) begin
        logic [13:0] p;
        wr_en = 1'b0;
        if (d == 0) begin
          while (wq.size() > 0 && wq[0].slot == k) begin
            act_t a;
            a = wq.pop_front();
            if (a.kind == 0) begin
              wr_en   = 1'b1;
              wr_addr = a.a[AW-1:0];
              wr_data = a.d;
            end else begin
              msg_len = a.d[AW:0];
            end
          end
        end
        if (len == 0)     p = 14'h0;
        else if (scr)     p = ref_font(sh[(off + k) % len]);
        else if (k < len) p = ref_font(sh[k]);
        else              p = 14'h0;
        sbq.push_back(exp_t'{n_cyc + 1, 12'(1 << k), p,
                             (BLANK == 0) && (k == DIGITS - 1) && (d == DWELL - 1)});
        if (wr_en) sh[wr_addr] = wr_data;
        step();
      end
      if (BLANK != 0) begin
        wr_en = 1'b0;
        sbq.push_back(exp_t'{n_cyc + 1, 12'h0, 14'h0, k == DIGITS - 1});
        step();
      end
    end
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; msg_len = '0; scroll_en = 1'b0;
    for (int i = 0; i < MSG_DEPTH; i++) sh[i] = 8'h20;
    repeat (3) begin
      sbq.push_back(exp_t'{n_cyc + 1, 12'h0, 14'h0, 1'b0});
      step();
    end
    rst = 1'b0;

    // empty buffer, len 0: sel walks, segm stays dark
    frame(0, 0, 0, DIGITS);
    // load message and change msg_len mid-frame; this frame still uses len 0
    wq.push_back(act_t'{0, 0, 8'd0, "P"});
    wq.push_back(act_t'{1, 0, 8'd1, "u"});
    wq.push_back(act_t'{2, 0, 8'd2, "S"});
    wq.push_back(act_t'{3, 0, 8'd3, "S"});
    wq.push_back(act_t'{4, 0, 8'd4, "Y"});
    wq.push_back(act_t'{6, 1, 8'd0, 8'd5});
    frame(0, 0, 0, DIGITS);
    // static PUSSY, blanks beyond len
    frame(5, 0, 0, DIGITS);
    // write the digit being shown: old char now, new char next frame
    wq.push_back(act_t'{3, 0, 8'd3, "T"});
    frame(5, 0, 0, DIGITS);
    // unknown code blanks, lowercase folds, restore message
    wq.push_back(act_t'{0, 0, 8'd4, "?"});
    wq.push_back(act_t'{5, 0, 8'd4, "y"});
    wq.push_back(act_t'{11, 0, 8'd3, "S"});
    frame(5, 0, 0, DIGITS);
    frame(5, 0, 0, DIGITS);
    // scroll one character per frame, offset wraps 4 -> 0
    frame(5, 0, 1, DIGITS);
    frame(5, 1, 1, DIGITS);
    frame(5, 2, 1, DIGITS);
    frame(5, 3, 1, DIGITS);
    frame(5, 4, 1, DIGITS);
    frame(5, 0, 1, DIGITS);
    // reset at digit 6 while scrolling
    frame(5, 1, 1, 6);
    rst = 1'b1;
    scroll_en = 1'b0;
    sbq.push_back(exp_t'{n_cyc + 1, 12'h0, 14'h0, 1'b0});
    step();
    rst = 1'b0;
    for (int i = 0; i < MSG_DEPTH; i++) sh[i] = 8'h20;
    frame(0, 0, 0, DIGITS);
    // buffer cleared: static len 5 is all spaces
    wq.push_back(act_t'{0, 0, 8'd0, "A"});
    wq.push_back(act_t'{6, 0, 8'd1, "T"});
    frame(5, 0, 0, DIGITS);
    // scroll restarts at offset 0; oversized msg_len clamps to depth
    wq.push_back(act_t'{3, 1, 8'd0, 8'd40});
    frame(5, 0, 1, DIGITS);
    wq.push_back(act_t'{0, 0, 8'd31, "Z"});
    for (int o = 1; o < MSG_DEPTH; o++) frame(MSG_DEPTH, o, 1, DIGITS);
    frame(MSG_DEPTH, 0, 1, DIGITS);

    repeat (3) step();
    if (sbq.size() != 0) begin
      n_chk++;
      $display("FAIL drain got=%0d want=0", sbq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seg14_scroller.md
# seg14_scroller

Parametrised 14-segment multiplexed display driver with a writable message buffer and optional horizontal scrolling. It replaces fixed-text display drivers. A host writes ASCII characters into an internal message RAM, and the block time-multiplexes `DIGITS` common-select lines, driving the decoded 14-segment pattern for each digit. It sits between the user-project logic and the display pads.

## Interface
- `DIGITS`, 12: number of display digits / width of `sel`; 1..16.
- `MSG_DEPTH`, 32: message buffer entries (power of two, ≥ `DIGITS`); `AW = $clog2(MSG_DEPTH)`.
- `DWELL`, 1: clock cycles each digit stays selected; ≥ 1.
- `SCROLL_FRAMES`, 4: complete frames per one-character scroll step; ≥ 1.

- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `wr_en`  in  1: write strobe for message buffer.
- `wr_addr`  in  AW: buffer write address.
- `wr_data`  in  8: ASCII character.
- `msg_len`  in  AW+1: active message length, 0..`MSG_DEPTH`.
- `scroll_en`  in  1: 1 = scroll mode, 0 = static mode.
- `sel`  out  `DIGITS`: one-hot digit select, registered.
- `segm`  out  14: segment pattern, bit 13 = segment a, registered.
- `frame_done`  out  1: one-cycle pulse when the last digit slot of a frame ends.

## Operation
- Reset values: `sel` = 0, `segm` = 0, `frame_done` = 0. Digit index, dwell counter, frame counter and scroll offset are all 0. Every buffer entry is 0x20 (space). Active length is 0.
- Digit index `k` counts 0..`DIGITS`-1 and wraps to 0. It advances when the dwell counter reaches `DWELL`-1. The end of slot `DIGITS`-1 is a frame boundary.
- During slot `k`: `sel` = 1<<k and `segm` = font(char), where char is selected as follows:
  - Static mode: buffer[k] if k < len, otherwise space.
  - Scroll mode: buffer[(offset+k) mod len].
  - len = 0 in either mode: `segm` = 0, `sel` still cycles.
- Font: uppercase A–Z, digits 0–9 and space use the team `seg14_font` table. Lowercase letters map to uppercase. Any other code decodes to 0.
  - Reference patterns: A = 0x3BC0, S = 0x2DC0, T = 0x2012, U = 0x1F00, space = 0x0000.
- `msg_len` is sampled into the active length only at frame boundaries and after reset. Values above `MSG_DEPTH` clamp to `MSG_DEPTH`.
- Scrolling:
  - The frame counter counts frame boundaries. On the `SCROLL_FRAMES`-th boundary, offset becomes (offset+1) mod len and the frame counter clears.
  - Offset also clears to 0 whenever `scroll_en` = 0 or a newly sampled length would leave offset ≥ len.
- Writes take effect on the next rising edge. A same-cycle read of the written address returns the old value (read-before-write). Writes are accepted in any cycle except while `rst` = 1.
- Reset mid-frame: on the next edge all state returns to reset values and the buffer is re-cleared.

## Timing
- Pipeline latency: the digit index and buffer read resolve combinationally, and `sel`/`segm` register them. An output change is visible 1 cycle after the index change.
- The first edge after `rst` falls produces `sel` = 1, `segm` = font(space) = 0.
- Frame period = `DIGITS`×`DWELL` cycles, or `DIGITS`×(`DWELL`+1) with blanking enabled.
- `frame_done` asserts in the cycle that `sel` shows the final cycle of digit `DIGITS`-1.
- A `msg_len` change is visible from the first slot of the next frame.
- `sel` is never multi-hot in any cycle.

## Configuration
- `SEG14_BLANKING_EN` defined:
  - A one-cycle blank slot is inserted after each digit's dwell, with `sel` = 0 and `segm` = 0, to suppress ghosting.
  - `frame_done` pulses during the blank slot after the last digit.
- Undefined: no blank slots, and digits are back-to-back.

## Test plan
- Reset release, buffer untouched, len = 0: `sel` walks 0x001→0x800 repeating every 12 cycles (`DWELL` = 1); `segm` stays 0; `frame_done` is high every 12th cycle.
- Write "PUSSY" at 0..4, len = 5, static mode:
  - Slot 2 shows `sel` = 0x004, `segm` = 0x2DC0.
  - Slots 5..11 show `segm` = 0.
- Same message, scroll mode, `SCROLL_FRAMES` = 1: digit 0 shows P, then U, S, S, Y, P on successive frames, with the offset wrapping 4→0.
- Write to the address currently being displayed in the same cycle: that slot shows the old character and the next frame shows the new one. Change `msg_len` mid-frame: the new length applies only after `frame_done`.
- Assert `rst` at the mid-frame digit 6 while scrolling: the next cycle has `sel` = 0, `segm` = 0, offset 0, and buffer contents are all spaces.
- Build with `SEG14_BLANKING_EN`, `DWELL` = 2: the `sel` sequence is 0x001, 0x001, 0x000, 0x002…, the frame is 36 cycles, and there is never more than one bit set.
